bitscan_sched: RTL and testbench

- Sequencer that walks a WIDTH-bit request/enable mask and issues the index of every set bit, lowest index first, one per handshake.
- Built around a lowest-set-bit priority encoder.
- Used to iterate PMP entries and other pending-bit vectors, e.g. entry-by-entry configuration or check passes.
- Accepts one job (mask) at a time and reports completion with a count of issued indices.

---
 rtl/bitscan_sched_if.sv | 28 ++
 rtl/bitscan_sched.sv | 84 ++++++++
 tb/tb_bitscan_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitscan_sched_if.sv
// bitscan_sched_if: mask-load, index-issue and completion signals of the bit-scan sequencer.
interface bitscan_sched_if #(
    parameter int WIDTH = 34,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int NUM_W = $clog2(WIDTH + 1)
);
    logic             flush_i;
    logic             load_valid_i;
    logic             load_ready_o;
    logic [WIDTH-1:0] load_mask_i;
    logic             idx_valid_o;
    logic             idx_ready_i;
    logic [CNT_W-1:0] idx_o;
    logic             idx_last_o;
    logic             busy_o;
    logic             done_o;
    logic [NUM_W-1:0] done_cnt_o;

    modport slave (
        input  flush_i, load_valid_i, load_mask_i, idx_ready_i,
        output load_ready_o, idx_valid_o, idx_o, idx_last_o, busy_o, done_o, done_cnt_o
    );

    modport master (
        output flush_i, load_valid_i, load_mask_i, idx_ready_i,
        input  load_ready_o, idx_valid_o, idx_o, idx_last_o, busy_o, done_o, done_cnt_o
    );
endinterface

// File: rtl/bitscan_sched.sv
// bitscan_sched: walks a mask and issues each set bit index, lowest first, one per handshake.
module bitscan_sched #(
    parameter int WIDTH = 34,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int NUM_W = $clog2(WIDTH + 1)
) (
    input logic            clk_i,
    input logic            rst_i,
    bitscan_sched_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d, mask_rest;
    logic [NUM_W-1:0] issued_q, issued_d, done_cnt_q, done_cnt_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] idx;
    logic             last, hs;

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (mask_q[i]) idx = CNT_W'(i);
    end

    // mask & (mask-1) drops the lowest set bit; empty remainder means exactly one bit left
    assign mask_rest = mask_q & (mask_q - WIDTH'(1));
    assign last      = (state_q == SCAN) && (mask_q != '0) && (mask_rest == '0);
    assign hs        = (state_q == SCAN) && bus.idx_ready_i && !bus.flush_i;

    assign bus.load_ready_o = (state_q == IDLE) && !bus.flush_i;
    assign bus.idx_valid_o  = (state_q == SCAN);
    assign bus.busy_o       = (state_q == SCAN);
    assign bus.idx_o        = idx;
    assign bus.idx_last_o   = last;
    assign bus.done_o       = done_q;
    assign bus.done_cnt_o   = done_cnt_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        issued_d   = issued_q;
        done_d     = 1'b0;
        done_cnt_d = done_cnt_q;
        if (bus.flush_i) begin
            state_d  = IDLE;
            mask_d   = '0;
            issued_d = '0;
        end else if (state_q == IDLE && bus.load_valid_i) begin
            if (bus.load_mask_i != '0) begin
                state_d  = SCAN;
                mask_d   = bus.load_mask_i;
                issued_d = '0;
            end else begin
                done_d     = 1'b1;
                done_cnt_d = '0;
            end
        end else if (hs) begin
            mask_d   = mask_rest;
            issued_d = issued_q + NUM_W'(1);
            if (last) begin
                state_d    = IDLE;
                done_d     = 1'b1;
                done_cnt_d = issued_q + NUM_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            issued_q   <= '0;
            done_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            done_cnt_q <= done_cnt_d;
        end
    end
endmodule

// File: tb/tb_bitscan_sched.sv
// tb_bitscan_sched: scenario tasks drive jobs; a negedge scoreboard checks every issued index and done pulse.
module tb_bitscan_sched;
    localparam int W  = 34;
    localparam int CW = $clog2(W);
    localparam int NW = $clog2(W + 1);

    typedef struct {
        logic [CW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   exp_done[$];

    bitscan_sched_if #(.WIDTH(W)) bus ();
    bitscan_sched #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so values seen at a negedge are those the next edge uses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.idx_valid_o === 1'b1 && bus.idx_ready_i && !bus.flush_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL idx_unexpected: got idx %0d last %0b, required no index", bus.idx_o, bus.idx_last_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({bus.idx_o, bus.idx_last_o} !== {e.idx, e.last}) begin
                        n_err++;
                        $display("FAIL idx_issue: got idx %0d last %0b, required idx %0d last %0b", bus.idx_o, bus.idx_last_o, e.idx, e.last);
                    end
                end
            end
            if (bus.done_o === 1'b1) begin
                n_cmp++;
                if (exp_done.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected: got done_o=1 cnt %0d, required no done pulse", bus.done_cnt_o);
                end else begin
                    int c;
                    c = exp_done.pop_front();
                    if (bus.done_cnt_o !== NW'(c)) begin
                        n_err++;
                        $display("FAIL done_cnt: got %0d, required %0d", bus.done_cnt_o, c);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [W-1:0] m, input bit with_done);
        for (int i = 0; i < W; i++)
            if (m[i]) exp_q.push_back('{idx: CW'(i), last: ((m >> (i + 1)) == '0)});
        if (with_done) exp_done.push_back($countones(m));
    endtask

    task automatic start_job(input logic [W-1:0] m, input logic rdy, input bit with_done);
        step();
        bus.load_valid_i = 1'b1;
        bus.load_mask_i  = m;
        bus.idx_ready_i  = rdy;
        push_job(m, with_done);
        step();
        bus.load_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bus.flush_i = 0; bus.load_valid_i = 0; bus.load_mask_i = '0; bus.idx_ready_i = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.load_ready_o, bus.idx_valid_o, bus.busy_o, bus.done_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctl: got ready/valid/busy/done %b, required 1000", {bus.load_ready_o, bus.idx_valid_o, bus.busy_o, bus.done_o});
        end
        n_cmp++;
        if ({bus.idx_o, bus.idx_last_o, bus.done_cnt_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got idx %0d last %0b cnt %0d, required all 0", bus.idx_o, bus.idx_last_o, bus.done_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_job(34'h2_0000_0005, 1'b1, 1);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 4) begin
            n_err++;
            $display("FAIL b2b_latency: got done after %0d cycles, required 4", cyc);
        end
        n_cmp++;
        if (bus.load_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_at_done: got %b, required 1", bus.load_ready_o);
        end
    endtask

    task automatic test_stall();
        int cyc;
        start_job(34'h0A0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.idx_valid_o, bus.idx_o, bus.idx_last_o} !== {1'b1, CW'(5), 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold: got valid %b idx %0d last %b, required 1/5/0", bus.idx_valid_o, bus.idx_o, bus.idx_last_o);
            end
        end
        step();
        bus.idx_ready_i = 1'b1;
        wait_done(cyc);
        n_cmp++;
        if (cyc != 3) begin
            n_err++;
            $display("FAIL stall_done: got done after %0d cycles, required 3", cyc);
        end
    endtask

    task automatic test_zero_mask();
        int cyc;
        start_job('0, 1'b1, 1);
        @(negedge clk);
        n_cmp++;
        if ({bus.idx_valid_o, bus.done_o, bus.load_ready_o} !== 3'b011) begin
            n_err++;
            $display("FAIL zero_mask: got valid/done/ready %b, required 011", {bus.idx_valid_o, bus.done_o, bus.load_ready_o});
        end
        step();
        n_cmp++;
        if (bus.idx_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL zero_mask_valid: got %b, required 0", bus.idx_valid_o);
        end
        cyc = 0;
    endtask

    task automatic test_flush();
        int cyc;
        start_job(34'h0F0, 1'b1, 0);
        step();
        bus.flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.load_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: got %b, required 0", bus.load_ready_o);
        end
        step();
        bus.flush_i = 1'b0;
        exp_q.delete();
        bus.load_valid_i = 1'b1;
        bus.load_mask_i  = 34'h1;
        push_job(34'h1, 1);
        @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.idx_valid_o, bus.done_o, bus.load_ready_o} !== 4'b0001) begin
            n_err++;
            $display("FAIL flush_idle: got busy/valid/done/ready %b, required 0001", {bus.busy_o, bus.idx_valid_o, bus.done_o, bus.load_ready_o});
        end
        step();
        bus.load_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_reload: got busy %b, required 1", bus.busy_o);
        end
        wait_done(cyc);
        n_cmp++;
        if (cyc < 0) begin
            n_err++;
            $display("FAIL flush_reload_done: got timeout, required done pulse");
        end
    endtask

    task automatic test_all_ones();
        int cyc;
        start_job('1, 1'b1, 1);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 35) begin
            n_err++;
            $display("FAIL all_ones_latency: got done after %0d cycles, required 35", cyc);
        end
    endtask

    task automatic test_reset_mid();
        start_job(34'h3FF, 1'b1, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({bus.load_ready_o, bus.idx_valid_o, bus.busy_o, bus.done_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_ctl: got ready/valid/busy/done %b, required 1000", {bus.load_ready_o, bus.idx_valid_o, bus.busy_o, bus.done_o});
        end
        n_cmp++;
        if ({bus.idx_o, bus.idx_last_o, bus.done_cnt_o} !== '0) begin
            n_err++;
            $display("FAIL midrst_data: got idx %0d last %0b cnt %0d, required all 0", bus.idx_o, bus.idx_last_o, bus.done_cnt_o);
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_zero_mask();
        test_flush();
        test_all_ones();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0 || exp_done.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d idx and %0d done left, required 0 and 0", exp_q.size(), exp_done.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
